// File: rtl/neo_pal_arb_pkg.sv
// neo_pal_arb_pkg
// Shared types and constants for the palette / memcard bus arbiter.
//   state_t   : access sequencer states
//   GC_*      : bus-switch codes packed as {G0, G1, DIR}
//   gcode_for : picks the bus-switch code for a latched access type
package neo_pal_arb_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_PWR,
    S_PRD_A,
    S_PRD_C,
    S_MC,
    S_ACK,
    S_REL
  } state_t;

  // {G0, G1, DIR}; G0 and G1 are never low together, DIR=1 drives toward the 68k
  localparam logic [2:0] GC_IDLE   = 3'b111;
  localparam logic [2:0] GC_PAL_WR = 3'b100;
  localparam logic [2:0] GC_PAL_RD = 3'b101;
  localparam logic [2:0] GC_MC_WR  = 3'b010;
  localparam logic [2:0] GC_MC_RD  = 3'b011;

  // sel: 0=palette, 1=memcard; rw: 1=read, 0=write
  function automatic logic [2:0] gcode_for(input logic sel, input logic rw);
    if (sel) return rw ? GC_MC_RD : GC_MC_WR;
    else     return rw ? GC_PAL_RD : GC_PAL_WR;
  endfunction

endpackage

// File: rtl/neo_pal_arb.sv
// neo_pal_arb
// Sequences 68k palette / memcard accesses onto the G0/G1/DIR bus switch and
// shares the single-port palette RAM with the video fetch (video always wins).
// Ports:
//   CLK, RESET            : clock, synchronous active-high reset
//   CPU_REQ/RW/SEL/ADDR   : CPU access request, latched in IDLE
//   PAL_BANK              : palette bank, top bit of PAL_ADDR
//   CPU_ACK, CPU_RDATA    : one-cycle completion pulse, captured read data
//   G0, G1, DIR           : bus-switch control
//   PAL_ADDR, PAL_WE, PAL_Q : palette RAM (one-cycle read latency)
//   MC_ADDR, MC_WE, MC_Q  : memcard
//   PIX_CE, VID_ADDR, VID_DATA : video palette slot, index, fetched colour
module neo_pal_arb
  import neo_pal_arb_pkg::*;
#(
  parameter int MC_AW   = 11,
  parameter int MC_WAIT = 3
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             CPU_REQ,
  input  logic             CPU_RW,
  input  logic             CPU_SEL,
  input  logic [11:0]      CPU_ADDR,
  input  logic             PAL_BANK,
  output logic             CPU_ACK,
  output logic [15:0]      CPU_RDATA,
  output logic             G0,
  output logic             G1,
  output logic             DIR,
  output logic [12:0]      PAL_ADDR,
  output logic             PAL_WE,
  input  logic [15:0]      PAL_Q,
  output logic [MC_AW-1:0] MC_ADDR,
  output logic             MC_WE,
  input  logic [15:0]      MC_Q,
  input  logic             PIX_CE,
  input  logic [11:0]      VID_ADDR,
  output logic [15:0]      VID_DATA
);

  state_t      state;
  state_t      state_nxt;
  logic        rw_reg;
  logic        sel_reg;
  logic [11:0] addr_reg;
  logic [3:0]  wait_cnt;
  logic        mc_last;
  logic        pix_ce_d;
  logic [2:0]  gcode;

  assign mc_last = (wait_cnt == 4'd1);

  // Video owns the RAM address whenever it has a slot
  assign PAL_ADDR = PIX_CE ? {PAL_BANK, VID_ADDR} : {PAL_BANK, addr_reg};

  assign {G0, G1, DIR} = gcode;

  // State register, request latch, memcard wait counter and data capture
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= S_IDLE;
      rw_reg    <= 1'b1;
      sel_reg   <= 1'b0;
      addr_reg  <= '0;
      wait_cnt  <= '0;
      pix_ce_d  <= 1'b0;
      CPU_RDATA <= '0;
      VID_DATA  <= '0;
      MC_ADDR   <= '0;
    end else begin
      state    <= state_nxt;
      pix_ce_d <= PIX_CE;

      // RAM answers one cycle after the video slot addressed it
      if (pix_ce_d) VID_DATA <= PAL_Q;

      if (state == S_IDLE && CPU_REQ) begin
        rw_reg   <= CPU_RW;
        sel_reg  <= CPU_SEL;
        addr_reg <= CPU_ADDR;
        if (CPU_SEL) MC_ADDR <= CPU_ADDR[MC_AW-1:0];
      end

      if (state == S_SETUP) wait_cnt <= 4'(MC_WAIT);
      else if (state == S_MC && wait_cnt != 4'd0) wait_cnt <= wait_cnt - 4'd1;

      // Captures are skipped for an abandoned request so CPU_RDATA keeps
      // the last acknowledged word
      if (CPU_REQ && state == S_PRD_C) CPU_RDATA <= PAL_Q;
      if (CPU_REQ && state == S_MC && rw_reg && mc_last) CPU_RDATA <= MC_Q;
    end
  end

  // Next state, strobes, acknowledge and bus-switch code
  always_comb begin
    state_nxt = state;
    PAL_WE    = 1'b0;
    MC_WE     = 1'b0;
    CPU_ACK   = 1'b0;
    gcode     = GC_IDLE;
    unique case (state)
      S_IDLE: begin
        if (CPU_REQ) state_nxt = S_SETUP;
      end
      S_SETUP: begin
        gcode = gcode_for(sel_reg, rw_reg);
        if (!CPU_REQ)     state_nxt = S_IDLE;
        else if (sel_reg) state_nxt = S_MC;
        else if (rw_reg)  state_nxt = S_PRD_A;
        else              state_nxt = S_PWR;
      end
      S_PWR: begin
        gcode  = gcode_for(sel_reg, rw_reg);
        // A strobe already in this cycle finishes even if the request drops
        PAL_WE = !PIX_CE;
        if (!CPU_REQ)     state_nxt = S_IDLE;
        else if (!PIX_CE) state_nxt = S_ACK;
      end
      S_PRD_A: begin
        gcode = gcode_for(sel_reg, rw_reg);
        if (!CPU_REQ)     state_nxt = S_IDLE;
        else if (!PIX_CE) state_nxt = S_PRD_C;
      end
      S_PRD_C: begin
        gcode     = gcode_for(sel_reg, rw_reg);
        state_nxt = CPU_REQ ? S_ACK : S_IDLE;
      end
      S_MC: begin
        gcode = gcode_for(sel_reg, rw_reg);
        MC_WE = !rw_reg;
        if (!CPU_REQ)     state_nxt = S_IDLE;
        else if (mc_last) state_nxt = S_ACK;
      end
      S_ACK: begin
        gcode     = gcode_for(sel_reg, rw_reg);
        CPU_ACK   = 1'b1;
        state_nxt = S_REL;
      end
      S_REL: begin
        // A request still held high must not restart an access
        if (!CPU_REQ) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_neo_pal_arb.sv
// tb_neo_pal_arb
// Directed bench for neo_pal_arb. Palette RAM model returns {3'b101, addr}
// one cycle after the address, so e.g. bank 0 index 0x789 reads 0xA789.
module tb_neo_pal_arb;

  localparam int MC_AW = 11;

  logic             CLK = 1'b0;
  logic             RESET;
  logic             CPU_REQ;
  logic             CPU_RW;
  logic             CPU_SEL;
  logic [11:0]      CPU_ADDR;
  logic             PAL_BANK;
  logic             CPU_ACK;
  logic [15:0]      CPU_RDATA;
  logic             G0, G1, DIR;
  logic [12:0]      PAL_ADDR;
  logic             PAL_WE;
  logic [15:0]      PAL_Q;
  logic [MC_AW-1:0] MC_ADDR;
  logic             MC_WE;
  logic [15:0]      MC_Q;
  logic             PIX_CE;
  logic [11:0]      VID_ADDR;
  logic [15:0]      VID_DATA;

  typedef struct {
    int          cyc;
    logic [15:0] data;
    bit          chk;
  } exp_t;

  exp_t ack_q[$];
  exp_t vid_q[$];

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;
  int pwe_count  = 0;
  int mwe_count  = 0;
  int ack_count  = 0;
  logic [12:0]      pwe_addr = '0;
  logic [MC_AW-1:0] mwe_addr = '0;
  int c0;
  int pwe_base;
  int mwe_base;

  neo_pal_arb #(.MC_AW(MC_AW), .MC_WAIT(3)) dut (
    .CLK(CLK), .RESET(RESET),
    .CPU_REQ(CPU_REQ), .CPU_RW(CPU_RW), .CPU_SEL(CPU_SEL), .CPU_ADDR(CPU_ADDR),
    .PAL_BANK(PAL_BANK), .CPU_ACK(CPU_ACK), .CPU_RDATA(CPU_RDATA),
    .G0(G0), .G1(G1), .DIR(DIR),
    .PAL_ADDR(PAL_ADDR), .PAL_WE(PAL_WE), .PAL_Q(PAL_Q),
    .MC_ADDR(MC_ADDR), .MC_WE(MC_WE), .MC_Q(MC_Q),
    .PIX_CE(PIX_CE), .VID_ADDR(VID_ADDR), .VID_DATA(VID_DATA)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // Synchronous palette RAM model
  always @(posedge CLK) PAL_Q <= {3'b101, PAL_ADDR};

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops scoreboards when the DUT acknowledges or a video word is due
  always @(negedge CLK) begin
    exp_t e;
    if (PAL_WE) begin pwe_count++; pwe_addr = PAL_ADDR; end
    if (MC_WE)  begin mwe_count++; mwe_addr = MC_ADDR;  end
    if (CPU_ACK) begin
      ack_count++;
      if (ack_q.size() == 0) begin
        checkOutput("ack_unexpected", 32'(CPU_ACK), 32'd0);
      end else begin
        e = ack_q.pop_front();
        checkOutput("ack_cycle", 32'(cyc), 32'(e.cyc));
        if (e.chk) checkOutput("ack_rdata", 32'(CPU_RDATA), 32'(e.data));
      end
    end else if (ack_q.size() > 0 && cyc > ack_q[0].cyc) begin
      e = ack_q.pop_front();
      checkOutput("ack_missing", 32'(CPU_ACK), 32'd1);
    end
    if (vid_q.size() > 0 && vid_q[0].cyc == cyc) begin
      e = vid_q.pop_front();
      checkOutput("vid_data", 32'(VID_DATA), 32'(e.data));
    end
    checkOutput("g_legal", 32'({G0, G1} == 2'b00), 32'd0);
    checkOutput("we_vs_pixce", 32'(PAL_WE & PIX_CE), 32'd0);
  end

  // Drive one cycle of inputs, check the combinational outputs mid-cycle,
  // then advance to just after the next rising edge
  task automatic applyStimulus(
    input string       tag,
    input logic        req, rw, sel,
    input logic [11:0] addr,
    input logic        pix, bank, rst,
    input logic [15:0] mcq,
    input logic [2:0]  exp_g,
    input logic        exp_pwe, exp_mwe, exp_ack
  );
    CPU_REQ  = req;
    CPU_RW   = rw;
    CPU_SEL  = sel;
    CPU_ADDR = addr;
    PIX_CE   = pix;
    PAL_BANK = bank;
    RESET    = rst;
    MC_Q     = mcq;
    if (pix) vid_q.push_back('{cyc + 2, bank ? 16'hB123 : 16'hA123, 1'b1});
    @(negedge CLK);
    checkOutput({tag, " g"},   32'({G0, G1, DIR}), 32'(exp_g));
    checkOutput({tag, " pwe"}, 32'(PAL_WE),  32'(exp_pwe));
    checkOutput({tag, " mwe"}, 32'(MC_WE),   32'(exp_mwe));
    checkOutput({tag, " ack"}, 32'(CPU_ACK), 32'(exp_ack));
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    RESET = 1'b1; CPU_REQ = 1'b0; CPU_RW = 1'b1; CPU_SEL = 1'b0; CPU_ADDR = '0;
    PAL_BANK = 1'b0; MC_Q = '0; PIX_CE = 1'b0; VID_ADDR = 12'h123;
    repeat (3) @(posedge CLK);
    #1;
    @(negedge CLK);
    checkOutput("rst g",      32'({G0, G1, DIR}), 32'h7);
    checkOutput("rst pwe",    32'(PAL_WE), 32'd0);
    checkOutput("rst mwe",    32'(MC_WE), 32'd0);
    checkOutput("rst ack",    32'(CPU_ACK), 32'd0);
    checkOutput("rst rdata",  32'(CPU_RDATA), 32'd0);
    checkOutput("rst vdata",  32'(VID_DATA), 32'd0);
    checkOutput("rst mcaddr", 32'(MC_ADDR), 32'd0);
    @(posedge CLK);
    #1;

    // Idle with video slots every 4th cycle, bank switching halfway
    pwe_base = pwe_count; mwe_base = mwe_count;
    for (int i = 0; i < 16; i++)
      applyStimulus("idle", 0, 1, 0, 12'h000, (i % 4) == 0, i >= 8, 0, 16'h0, 3'b111, 0, 0, 0);
    checkOutput("idle pwe_cnt", 32'(pwe_count - pwe_base), 32'd0);
    checkOutput("idle mwe_cnt", 32'(mwe_count - mwe_base), 32'd0);

    // Palette write 0x456, bank 1, request held through REL
    pwe_base = pwe_count; c0 = cyc;
    ack_q.push_back('{c0 + 3, 16'h0000, 1'b0});
    applyStimulus("pw c0", 1, 0, 0, 12'h456, 0, 1, 0, 16'h0, 3'b111, 0, 0, 0);
    applyStimulus("pw c1", 1, 0, 0, 12'h456, 0, 1, 0, 16'h0, 3'b100, 0, 0, 0);
    applyStimulus("pw c2", 1, 0, 0, 12'h456, 0, 1, 0, 16'h0, 3'b100, 1, 0, 0);
    applyStimulus("pw c3", 1, 0, 0, 12'h456, 0, 1, 0, 16'h0, 3'b100, 0, 0, 1);
    applyStimulus("pw c4", 1, 0, 0, 12'h456, 0, 1, 0, 16'h0, 3'b111, 0, 0, 0);
    applyStimulus("pw c5", 1, 0, 0, 12'h456, 0, 1, 0, 16'h0, 3'b111, 0, 0, 0);
    applyStimulus("pw c6", 0, 0, 0, 12'h456, 0, 1, 0, 16'h0, 3'b111, 0, 0, 0);
    applyStimulus("pw c7", 0, 0, 0, 12'h456, 0, 1, 0, 16'h0, 3'b111, 0, 0, 0);
    checkOutput("pw pwe_cnt", 32'(pwe_count - pwe_base), 32'd1);
    checkOutput("pw addr",    32'(pwe_addr), 32'h1456);

    // Palette read 0x789 with video collision in PRD_A and a slot in PRD_C
    c0 = cyc;
    ack_q.push_back('{c0 + 5, 16'hA789, 1'b1});
    applyStimulus("pr c0", 1, 1, 0, 12'h789, 0, 0, 0, 16'h0, 3'b111, 0, 0, 0);
    applyStimulus("pr c1", 1, 1, 0, 12'h789, 0, 0, 0, 16'h0, 3'b101, 0, 0, 0);
    applyStimulus("pr c2", 1, 1, 0, 12'h789, 1, 0, 0, 16'h0, 3'b101, 0, 0, 0);
    applyStimulus("pr c3", 1, 1, 0, 12'h789, 0, 0, 0, 16'h0, 3'b101, 0, 0, 0);
    applyStimulus("pr c4", 1, 1, 0, 12'h789, 1, 0, 0, 16'h0, 3'b101, 0, 0, 0);
    applyStimulus("pr c5", 1, 1, 0, 12'h789, 0, 0, 0, 16'h0, 3'b101, 0, 0, 1);
    applyStimulus("pr c6", 0, 1, 0, 12'h789, 0, 0, 0, 16'h0, 3'b111, 0, 0, 0);
    applyStimulus("pr c7", 0, 1, 0, 12'h789, 0, 0, 0, 16'h0, 3'b111, 0, 0, 0);

    // Memcard write 0x7FF with video slots toggling
    pwe_base = pwe_count; mwe_base = mwe_count; c0 = cyc;
    ack_q.push_back('{c0 + 5, 16'h0000, 1'b0});
    applyStimulus("mw c0", 1, 0, 1, 12'h7FF, 0, 0, 0, 16'h0, 3'b111, 0, 0, 0);
    applyStimulus("mw c1", 1, 0, 1, 12'h7FF, 1, 0, 0, 16'h0, 3'b010, 0, 0, 0);
    applyStimulus("mw c2", 1, 0, 1, 12'h7FF, 0, 0, 0, 16'h0, 3'b010, 0, 1, 0);
    applyStimulus("mw c3", 1, 0, 1, 12'h7FF, 1, 0, 0, 16'h0, 3'b010, 0, 1, 0);
    applyStimulus("mw c4", 1, 0, 1, 12'h7FF, 0, 0, 0, 16'h0, 3'b010, 0, 1, 0);
    applyStimulus("mw c5", 1, 0, 1, 12'h7FF, 1, 0, 0, 16'h0, 3'b010, 0, 0, 1);
    applyStimulus("mw c6", 0, 0, 1, 12'h7FF, 0, 0, 0, 16'h0, 3'b111, 0, 0, 0);
    applyStimulus("mw c7", 0, 0, 1, 12'h7FF, 0, 0, 0, 16'h0, 3'b111, 0, 0, 0);
    checkOutput("mw mwe_cnt", 32'(mwe_count - mwe_base), 32'd3);
    checkOutput("mw pwe_cnt", 32'(pwe_count - pwe_base), 32'd0);
    checkOutput("mw addr",    32'(mwe_addr), 32'h7FF);

    // Memcard read 0x010; only the last wait cycle carries the real word
    c0 = cyc;
    ack_q.push_back('{c0 + 5, 16'hA55A, 1'b1});
    applyStimulus("mr c0", 1, 1, 1, 12'h010, 0, 0, 0, 16'h0000, 3'b111, 0, 0, 0);
    applyStimulus("mr c1", 1, 1, 1, 12'h010, 0, 0, 0, 16'h0000, 3'b011, 0, 0, 0);
    applyStimulus("mr c2", 1, 1, 1, 12'h010, 0, 0, 0, 16'h1111, 3'b011, 0, 0, 0);
    applyStimulus("mr c3", 1, 1, 1, 12'h010, 0, 0, 0, 16'h2222, 3'b011, 0, 0, 0);
    applyStimulus("mr c4", 1, 1, 1, 12'h010, 0, 0, 0, 16'hA55A, 3'b011, 0, 0, 0);
    applyStimulus("mr c5", 1, 1, 1, 12'h010, 0, 0, 0, 16'h3333, 3'b011, 0, 0, 1);
    applyStimulus("mr c6", 0, 1, 1, 12'h010, 0, 0, 0, 16'h0000, 3'b111, 0, 0, 0);
    applyStimulus("mr c7", 0, 1, 1, 12'h010, 0, 0, 0, 16'h0000, 3'b111, 0, 0, 0);
    checkOutput("mr mcaddr", 32'(MC_ADDR), 32'h010);

    // Reset during PWR abandons the write
    pwe_base = pwe_count;
    applyStimulus("rs c0", 1, 0, 0, 12'h100, 0, 0, 0, 16'h0, 3'b111, 0, 0, 0);
    applyStimulus("rs c1", 1, 0, 0, 12'h100, 0, 0, 0, 16'h0, 3'b100, 0, 0, 0);
    applyStimulus("rs c2", 1, 0, 0, 12'h100, 0, 0, 1, 16'h0, 3'b100, 1, 0, 0);
    applyStimulus("rs c3", 0, 0, 0, 12'h100, 0, 0, 0, 16'h0, 3'b111, 0, 0, 0);
    applyStimulus("rs c4", 0, 0, 0, 12'h100, 0, 0, 0, 16'h0, 3'b111, 0, 0, 0);
    checkOutput("rs pwe_cnt", 32'(pwe_count - pwe_base), 32'd1);
    checkOutput("rs rdata",   32'(CPU_RDATA), 32'd0);
    checkOutput("rs mcaddr",  32'(MC_ADDR), 32'd0);

    // Request dropped while in PRD_A
    applyStimulus("dr c0", 1, 1, 0, 12'h200, 0, 0, 0, 16'h0, 3'b111, 0, 0, 0);
    applyStimulus("dr c1", 1, 1, 0, 12'h200, 0, 0, 0, 16'h0, 3'b101, 0, 0, 0);
    applyStimulus("dr c2", 0, 1, 0, 12'h200, 0, 0, 0, 16'h0, 3'b101, 0, 0, 0);
    applyStimulus("dr c3", 0, 1, 0, 12'h200, 0, 0, 0, 16'h0, 3'b111, 0, 0, 0);
    applyStimulus("dr c4", 0, 1, 0, 12'h200, 0, 0, 0, 16'h0, 3'b111, 0, 0, 0);
    applyStimulus("dr c5", 0, 1, 0, 12'h200, 0, 0, 0, 16'h0, 3'b111, 0, 0, 0);
    checkOutput("dr rdata", 32'(CPU_RDATA), 32'd0);

    repeat (3) @(posedge CLK);
    @(negedge CLK);
    checkOutput("ack_q empty", 32'(ack_q.size()), 32'd0);
    checkOutput("vid_q empty", 32'(vid_q.size()), 32'd0);
    checkOutput("ack total",   32'(ack_count), 32'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/neo_pal_arb.md
Name: neo_pal_arb

Overview:
Controller for the G0/G1/DIR bus switch between the 68k data bus, palette RAM (PC) and memory card (CDD). Sequences each CPU palette or memcard access into a legal G0/G1/DIR code, write-strobe pulse, read-data capture and DTACK-style acknowledge. Shares the single-port palette RAM between the CPU and the video pixel fetch; video always has priority. Sits between the 68k address decode and the palette RAM / memcard, beside the bus-switch block it drives.

Parameters:
MC_AW, 11, memcard word-address width (taken from CPU_ADDR[MC_AW-1:0]).
MC_WAIT, 3, memcard strobe/wait length in CLK cycles (1..15).

Ports:
CLK  in  1  system clock
RESET  in  1  synchronous, active-high reset
CPU_REQ  in  1  level request; held by CPU until CPU_ACK seen, then dropped
CPU_RW  in  1  1=read, 0=write; sampled in IDLE
CPU_SEL  in  1  0=palette, 1=memcard; sampled in IDLE
CPU_ADDR  in  12  word address; sampled in IDLE
PAL_BANK  in  1  palette bank select, concatenated as PAL_ADDR[12]
CPU_ACK  out  1  one-cycle completion pulse
CPU_RDATA  out  16  captured read data, valid from CPU_ACK cycle until next capture
G0  out  1  bus-switch select 0
G1  out  1  bus-switch select 1
DIR  out  1  bus-switch direction, 1=toward 68k
PAL_ADDR  out  13  palette RAM address, combinational mux
PAL_WE  out  1  palette write strobe, active high
PAL_Q  in  16  palette RAM read data, one-cycle synchronous latency
MC_ADDR  out  MC_AW  memcard address, registered
MC_WE  out  1  memcard write strobe, active high
MC_Q  in  16  memcard read data, valid by the last wait cycle
PIX_CE  in  1  video palette slot strobe
VID_ADDR  in  12  video palette index
VID_DATA  out  16  registered video palette colour

Behaviour:
- Reset: state IDLE; G0=G1=DIR=1; PAL_WE=MC_WE=CPU_ACK=0; CPU_RDATA, VID_DATA, MC_ADDR = 0. A reset in mid-access abandons the access with no ACK and no further strobe.
- G codes (G0,G1,DIR): idle 1,1,1; palette write 1,0,0; palette read 1,0,1; memcard write 0,1,0; memcard read 0,1,1. G0=G1=0 is never driven.
- PAL_ADDR = PIX_CE ? {PAL_BANK,VID_ADDR} : {PAL_BANK,cpu_addr_reg}.
- Video: PIX_CE at cycle n means VID_DATA <= PAL_Q at the end of n+1, so it is valid from n+2. This holds regardless of CPU state.
- States: IDLE, SETUP, PWR, PRD_A, PRD_C, MC, ACK, REL.
- IDLE: when CPU_REQ=1, latch RW/SEL/ADDR and go to SETUP. The G code is driven from SETUP through ACK.
- SETUP, 1 cycle: goes to PWR, PRD_A or MC. For MC, load the wait counter with MC_WAIT.
- PWR: if PIX_CE=1, hold with PAL_WE=0. Otherwise PAL_WE=1 for exactly one cycle, then go to ACK. PAL_WE is never high while PIX_CE=1.
- PRD_A: if PIX_CE=1, hold. Otherwise the CPU address is presented; go to PRD_C.
- PRD_C: CPU_RDATA <= PAL_Q, independent of PIX_CE this cycle; go to ACK.
- MC: ignores PIX_CE. MC_WE=1 for all MC_WAIT cycles on a write. On a read, CPU_RDATA <= MC_Q in the last wait cycle. Then go to ACK.
- ACK: CPU_ACK=1 for one cycle, then REL. The G code returns to 1,1,1 in REL.
- REL: wait for CPU_REQ=0, then IDLE. A request held high never starts a second access.
- CPU_REQ dropped before ACK: go to IDLE next cycle with no ACK. A strobe asserted in the current cycle completes; no strobe is issued afterwards.
- Best-case latency from the CPU_REQ rising cycle to CPU_ACK: palette write 3 cycles; palette read 4 cycles; memcard 2+MC_WAIT cycles. Each PIX_CE collision adds 1 cycle.

Decomposition:
- Shared package neo_pal_arb_pkg: state enum; G-code constants GC_IDLE, GC_PAL_WR, GC_PAL_RD, GC_MC_WR, GC_MC_RD (3-bit {G0,G1,DIR}).
- Single module; the 4-bit wait counter is inline. No sub-module.

Test Plan:
- Reset, then idle with PIX_CE every 4th cycle, VID_ADDR=0x123, PAL_Q model -> G0/G1/DIR=111; VID_DATA = mem[{PAL_BANK,0x123}] two cycles after each PIX_CE; no WE ever.
- Palette write to 0x0456, PAL_BANK=1, PIX_CE low -> G=100 from cycle 1; PAL_WE pulse at cycle 2 with PAL_ADDR=0x1456; CPU_ACK at cycle 3; REL held while REQ stays high.
- Palette read with PIX_CE high on the PRD_A cycle -> PRD_A holds 1 extra cycle; CPU_RDATA = mem[cpu addr], not the video word; ACK at cycle 5.
- Memcard write to 0x7FF with MC_WAIT=3 and PIX_CE toggling -> G=010; MC_WE high exactly 3 cycles with MC_ADDR=0x7FF; ACK at cycle 5; PAL_WE=0 throughout.
- Memcard read with MC_Q=0xA55A -> G=011; CPU_RDATA=0xA55A at ACK.
- RESET asserted in PWR, and separately CPU_REQ dropped in PRD_A -> next cycle IDLE, G=111, no ACK, no further PAL_WE/MC_WE.
